branch_ctrl: RTL and testbench

Decode-stage branch/jump resolution unit for the five-stage MIPS pipeline. It sits directly downstream of the branch equality comparator: it consumes the comparator's taken bit together with the ID-stage instruction fields. It then produces the registered PC redirect to fetch, the link-register write for JAL/JALR/BLTZAL/BGEZAL, the ID stall request, and the delay-slot marker. Redirects use a valid/ready handshake with the fetch stage, so fetch back-pressure never loses a branch.

---
 rtl/branch_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_branch_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: decode-stage branch and jump resolution for the five-stage MIPS pipeline.
// Decodes control-flow instructions in ID, waits for forwarded operands, and
// produces a registered PC redirect (valid/ready with fetch), a one-cycle link
// register write and a delay-slot marker.
module branch_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [5:0]  id_op,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [5:0]  id_funct,
    input  logic [15:0] id_imm,
    input  logic [25:0] id_index,
    input  logic [31:0] id_pc,
    input  logic [31:0] rs_value,
    input  logic        opnd_ready,
    input  logic        cmp_taken,
    input  logic        if_ready,
    output logic        stall_id,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        link_we,
    output logic [4:0]  link_reg,
    output logic [31:0] link_data,
    output logic        in_delay_slot
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        is_cond;
    logic        is_jump;
    logic        is_reg_jump;
    logic        is_link;
    logic [4:0]  link_dest;
    logic        is_cf;
    logic        taken;

    logic [31:0] pc4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target;
    logic [31:0] link_value;

    logic        resolve;
    logic        accept;

    // Classify the ID instruction: conditional branch, unconditional jump, register jump, and link destination
    always_comb begin
        is_cond     = 1'b0;
        is_jump     = 1'b0;
        is_reg_jump = 1'b0;
        is_link     = 1'b0;
        link_dest   = 5'd0;
        case (id_op)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                is_cond = 1'b1;
            end
            OP_REGIMM: begin
                case (id_rt)
                    RT_BLTZ, RT_BGEZ: begin
                        is_cond = 1'b1;
                    end
                    RT_BLTZAL, RT_BGEZAL: begin
                        is_cond   = 1'b1;
                        is_link   = 1'b1;
                        link_dest = REG_RA;
                    end
                    default: begin
                        is_cond = 1'b0;
                    end
                endcase
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            OP_JAL: begin
                is_jump   = 1'b1;
                is_link   = 1'b1;
                link_dest = REG_RA;
            end
            OP_SPECIAL: begin
                case (id_funct)
                    FN_JR: begin
                        is_jump     = 1'b1;
                        is_reg_jump = 1'b1;
                    end
                    FN_JALR: begin
                        is_jump     = 1'b1;
                        is_reg_jump = 1'b1;
                        is_link     = 1'b1;
                        link_dest   = id_rd;
                    end
                    default: begin
                        is_jump = 1'b0;
                    end
                endcase
            end
            default: begin
                is_cond = 1'b0;
            end
        endcase
    end

    assign is_cf = is_cond | is_jump;
    assign taken = is_jump | (is_cond & cmp_taken);

    // Target and link arithmetic; everything wraps modulo 2^32
    always_comb begin
        pc4           = id_pc + 32'd4;
        branch_offset = {{14{id_imm[15]}}, id_imm, 2'b00};
        branch_target = pc4 + branch_offset;
        jump_target   = {pc4[31:28], id_index, 2'b00};
        link_value    = id_pc + 32'd8;
        if (is_reg_jump) begin
            target = rs_value;
        end else if (is_cond) begin
            target = branch_target;
        end else begin
            target = jump_target;
        end
    end

    // State register; flush abandons any in-progress branch
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: wait out load-use hazards, hold until fetch takes the redirect
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (id_valid && is_cf) begin
                    if (!opnd_ready) begin
                        next_state = WAIT;
                    end else if (taken) begin
                        next_state = HOLD;
                    end
                end
            end
            WAIT: begin
                if (!(id_valid && is_cf)) begin
                    next_state = IDLE;
                end else if (opnd_ready) begin
                    next_state = taken ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (if_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Per-state outputs: ID stall, resolve strobe and redirect acceptance
    always_comb begin
        stall_id = 1'b0;
        resolve  = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE, WAIT: begin
                if (id_valid && is_cf) begin
                    if (!opnd_ready) begin
                        stall_id = 1'b1;
                    end else begin
                        resolve = 1'b1;
                    end
                end
            end
            HOLD: begin
                stall_id = 1'b1;
                accept   = if_ready;
            end
            default: begin
                stall_id = 1'b0;
            end
        endcase
    end

    // Registered redirect, link pulse and delay-slot flag; set on resolve takes priority over clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            link_we        <= 1'b0;
            link_reg       <= 5'd0;
            link_data      <= 32'd0;
            in_delay_slot  <= 1'b0;
        end else if (flush) begin
            redirect_valid <= 1'b0;
            link_we        <= 1'b0;
            in_delay_slot  <= 1'b0;
        end else begin
            link_we <= resolve & is_link;
            if (resolve) begin
                in_delay_slot <= 1'b1;
                if (is_link) begin
                    link_reg  <= link_dest;
                    link_data <= link_value;
                end
                if (taken) begin
                    redirect_valid <= 1'b1;
                    redirect_pc    <= target;
                end
            end else begin
                if (accept) begin
                    redirect_valid <= 1'b0;
                end
                if (id_valid && !stall_id) begin
                    in_delay_slot <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed-vector bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        id_valid;
    logic [5:0]  id_op;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [5:0]  id_funct;
    logic [15:0] id_imm;
    logic [25:0] id_index;
    logic [31:0] id_pc;
    logic [31:0] rs_value;
    logic        opnd_ready;
    logic        cmp_taken;
    logic        if_ready;
    logic        stall_id;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        link_we;
    logic [4:0]  link_reg;
    logic [31:0] link_data;
    logic        in_delay_slot;

    int checks;
    int errors;

    branch_ctrl dut (
        .clk            (clk),
        .resetn         (resetn),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_op          (id_op),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_funct       (id_funct),
        .id_imm         (id_imm),
        .id_index       (id_index),
        .id_pc          (id_pc),
        .rs_value       (rs_value),
        .opnd_ready     (opnd_ready),
        .cmp_taken      (cmp_taken),
        .if_ready       (if_ready),
        .stall_id       (stall_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .link_we        (link_we),
        .link_reg       (link_reg),
        .link_data      (link_data),
        .in_delay_slot  (in_delay_slot)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the ID-stage instruction fields and operand status
    task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                                 input logic [25:0] idx, input logic [31:0] pc, input logic [31:0] rs,
                                 input logic opnd, input logic cmp);
        id_valid   = v;
        id_op      = op;
        id_rt      = rt;
        id_rd      = rd;
        id_funct   = fn;
        id_imm     = imm;
        id_index   = idx;
        id_pc      = pc;
        rs_value   = rs;
        opnd_ready = opnd;
        cmp_taken  = cmp;
        #1;
    endtask

    // An ADD sitting in ID (SPECIAL, funct 100000): never control flow
    task automatic applyAdd(input logic [31:0] pc);
        applyStimulus(1'b1, 6'b000000, 5'd1, 5'd2, 6'b100000, 16'h0, 26'h0, pc, 32'h0, 1'b1, 1'b0);
    endtask

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetn   = 1'b0;
        flush    = 1'b0;
        if_ready = 1'b0;
        applyStimulus(1'b0, 6'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_rv",   {31'd0, redirect_valid}, 32'd0);
        checkOutput("rst_pc",   redirect_pc, 32'd0);
        checkOutput("rst_lwe",  {31'd0, link_we}, 32'd0);
        checkOutput("rst_ds",   {31'd0, in_delay_slot}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall_id}, 32'd0);
        resetn = 1'b1;

        // BEQ taken, backward offset, fetch ready immediately
        $display("[TB] BEQ taken");
        if_ready = 1'b1;
        applyStimulus(1'b1, 6'b000100, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0, 32'h00400010, 32'd0, 1'b1, 1'b1);
        checkOutput("beq_nostall", {31'd0, stall_id}, 32'd0);
        tick();
        checkOutput("beq_rv",    {31'd0, redirect_valid}, 32'd1);
        checkOutput("beq_pc",    redirect_pc, 32'h00400004);
        checkOutput("beq_lwe",   {31'd0, link_we}, 32'd0);
        checkOutput("beq_ds",    {31'd0, in_delay_slot}, 32'd1);
        checkOutput("beq_hold",  {31'd0, stall_id}, 32'd1);
        applyAdd(32'h00400014);
        tick();
        checkOutput("beq_rv_clr", {31'd0, redirect_valid}, 32'd0);
        checkOutput("beq_idle",   {31'd0, stall_id}, 32'd0);
        checkOutput("beq_ds_hold", {31'd0, in_delay_slot}, 32'd1);
        tick();
        checkOutput("beq_ds_clr", {31'd0, in_delay_slot}, 32'd0);

        // BGEZAL not taken still links
        $display("[TB] BGEZAL not taken");
        applyStimulus(1'b1, 6'b000001, 5'b10001, 5'd0, 6'd0, 16'h0004, 26'd0, 32'h00001000, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("bgezal_lwe",  {31'd0, link_we}, 32'd1);
        checkOutput("bgezal_lreg", {27'd0, link_reg}, 32'd31);
        checkOutput("bgezal_ldat", link_data, 32'h00001008);
        checkOutput("bgezal_rv",   {31'd0, redirect_valid}, 32'd0);
        checkOutput("bgezal_ds",   {31'd0, in_delay_slot}, 32'd1);
        applyStimulus(1'b0, 6'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("bgezal_lwe_once", {31'd0, link_we}, 32'd0);
        checkOutput("bgezal_ds_keep",  {31'd0, in_delay_slot}, 32'd1);
        applyAdd(32'h00001004);
        tick();
        checkOutput("bgezal_ds_clr", {31'd0, in_delay_slot}, 32'd0);
        checkOutput("bgezal_rv2",    {31'd0, redirect_valid}, 32'd0);

        // JAL with fetch back-pressure for three HOLD cycles
        $display("[TB] JAL with back-pressure");
        if_ready = 1'b0;
        applyStimulus(1'b1, 6'b000011, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000100, 32'hA0000FFC, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("jal_rv",   {31'd0, redirect_valid}, 32'd1);
        checkOutput("jal_pc",   redirect_pc, 32'hA0000400);
        checkOutput("jal_lwe",  {31'd0, link_we}, 32'd1);
        checkOutput("jal_lreg", {27'd0, link_reg}, 32'd31);
        checkOutput("jal_ldat", link_data, 32'hA0001004);
        applyAdd(32'hA0001000);
        checkOutput("jal_stall1", {31'd0, stall_id}, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            checkOutput("jal_rv_hold", {31'd0, redirect_valid}, 32'd1);
            checkOutput("jal_pc_hold", redirect_pc, 32'hA0000400);
            checkOutput("jal_stall",   {31'd0, stall_id}, 32'd1);
            checkOutput("jal_lwe_off", {31'd0, link_we}, 32'd0);
        end
        if_ready = 1'b1;
        tick();
        checkOutput("jal_accept", {31'd0, redirect_valid}, 32'd0);
        checkOutput("jal_idle",   {31'd0, stall_id}, 32'd0);
        tick();
        checkOutput("jal_ds_clr", {31'd0, in_delay_slot}, 32'd0);

        // JR waiting two cycles on a load-use hazard
        $display("[TB] JR with operand wait");
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 6'b001000, 16'd0, 26'd0, 32'h00000500, 32'h80001234, 1'b0, 1'b0);
        checkOutput("jr_stall1", {31'd0, stall_id}, 32'd1);
        tick();
        checkOutput("jr_stall2", {31'd0, stall_id}, 32'd1);
        checkOutput("jr_rv_wait", {31'd0, redirect_valid}, 32'd0);
        checkOutput("jr_lwe_wait", {31'd0, link_we}, 32'd0);
        checkOutput("jr_ds_wait", {31'd0, in_delay_slot}, 32'd0);
        tick();
        checkOutput("jr_rv_wait2", {31'd0, redirect_valid}, 32'd0);
        opnd_ready = 1'b1;
        tick();
        checkOutput("jr_rv",  {31'd0, redirect_valid}, 32'd1);
        checkOutput("jr_pc",  redirect_pc, 32'h80001234);
        checkOutput("jr_lwe", {31'd0, link_we}, 32'd0);
        checkOutput("jr_ds",  {31'd0, in_delay_slot}, 32'd1);
        applyAdd(32'h00000504);
        tick();
        checkOutput("jr_accept", {31'd0, redirect_valid}, 32'd0);
        tick();

        // BNE taken, flush in first HOLD cycle alongside if_ready
        $display("[TB] BNE taken then flush");
        if_ready = 1'b0;
        applyStimulus(1'b1, 6'b000101, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 32'h00002000, 32'd0, 1'b1, 1'b1);
        tick();
        checkOutput("bne_rv", {31'd0, redirect_valid}, 32'd1);
        checkOutput("bne_pc", redirect_pc, 32'h00002044);
        applyAdd(32'h00002004);
        flush    = 1'b1;
        if_ready = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checkOutput("bne_flush_rv",    {31'd0, redirect_valid}, 32'd0);
        checkOutput("bne_flush_ds",    {31'd0, in_delay_slot}, 32'd0);
        checkOutput("bne_flush_idle",  {31'd0, stall_id}, 32'd0);
        tick();
        checkOutput("bne_flush_rv2",   {31'd0, redirect_valid}, 32'd0);

        // JALR with rd = 0 still pulses link_we
        $display("[TB] JALR rd=0");
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd0, 6'b001001, 16'd0, 26'd0, 32'h00000100, 32'h00000003, 1'b1, 1'b0);
        tick();
        checkOutput("jalr_lwe",  {31'd0, link_we}, 32'd1);
        checkOutput("jalr_lreg", {27'd0, link_reg}, 32'd0);
        checkOutput("jalr_ldat", link_data, 32'h00000108);
        checkOutput("jalr_pc",   redirect_pc, 32'h00000003);
        applyAdd(32'h00000104);
        tick();
        tick();

        // Flush while waiting on operands: no link pulse or redirect follows
        $display("[TB] JALR flushed in WAIT");
        applyStimulus(1'b1, 6'b000000, 5'd0, 5'd5, 6'b001001, 16'd0, 26'd0, 32'h00000200, 32'h00004000, 1'b0, 1'b0);
        tick();
        checkOutput("wflush_stall", {31'd0, stall_id}, 32'd1);
        opnd_ready = 1'b1;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        applyAdd(32'h00000300);
        checkOutput("wflush_lwe", {31'd0, link_we}, 32'd0);
        checkOutput("wflush_rv",  {31'd0, redirect_valid}, 32'd0);
        checkOutput("wflush_ds",  {31'd0, in_delay_slot}, 32'd0);
        checkOutput("wflush_ldat", link_data, 32'h00000108);

        // Reset asserted mid-HOLD
        $display("[TB] reset in HOLD");
        if_ready = 1'b0;
        applyStimulus(1'b1, 6'b000010, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000040, 32'h00003000, 32'd0, 1'b1, 1'b0);
        tick();
        checkOutput("j_rv", {31'd0, redirect_valid}, 32'd1);
        checkOutput("j_pc", redirect_pc, 32'h00000100);
        applyAdd(32'h00003004);
        resetn = 1'b0;
        tick();
        checkOutput("hrst_rv",   {31'd0, redirect_valid}, 32'd0);
        checkOutput("hrst_pc",   redirect_pc, 32'd0);
        checkOutput("hrst_lwe",  {31'd0, link_we}, 32'd0);
        checkOutput("hrst_lreg", {27'd0, link_reg}, 32'd0);
        checkOutput("hrst_ldat", link_data, 32'd0);
        checkOutput("hrst_ds",   {31'd0, in_delay_slot}, 32'd0);
        resetn = 1'b1;
        applyAdd(32'h00003008);
        checkOutput("hrst_add_nostall", {31'd0, stall_id}, 32'd0);
        tick();
        checkOutput("hrst_add_nostall2", {31'd0, stall_id}, 32'd0);
        checkOutput("hrst_rv2", {31'd0, redirect_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
